// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter / fetch sequencer.
package pc_pkg;

  localparam int PC_W           = 10;
  localparam int DEF_START_ADDR = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-address unit: increment, absolute jump or signed relative
// branch, all in D-bit arithmetic with the carry discarded.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int D = PC_W
) (
  input  logic [D-1:0] prog_ctr,
  input  logic         branch,
  input  logic         abs_jump,
  input  logic [D-1:0] target,
  output logic [D-1:0] next_pc
);

  // A D-bit add of a two's-complement offset wraps identically to signed math.
  always_comb begin
    next_pc = prog_ctr + D'(1);
    if (branch) begin
      if (abs_jump) next_pc = target;
      else          next_pc = prog_ctr + target;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control, stall/halt
// priority and a saturating retired-instruction counter.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int D          = PC_W,
  parameter int START_ADDR = DEF_START_ADDR,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch,
  input  logic             abs_jump,
  input  logic [D-1:0]     target,
  input  logic             halt,
  output logic [D-1:0]     prog_ctr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [D-1:0] START_PC = START_ADDR[D-1:0];

  state_t           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [D-1:0]     next_pc;

  pc_next_calc #(.D(D)) u_next (
    .prog_ctr (pc_q),
    .branch   (branch),
    .abs_jump (abs_jump),
    .target   (target),
    .next_pc  (next_pc)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // The halt instruction itself retires, but the PC stays on it for readout.
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt) state_d = DONE;
          else      pc_d    = next_pc;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
        cnt_d   = '0;
      end
    endcase
  end

  assign prog_ctr  = pc_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a table of hand-computed vectors fed
// through a scoreboard queue, then a long run to exercise counter saturation.
module tb_pc_fetch_ctrl;

  localparam int D     = 10;
  localparam int CNT_W = 8;

  typedef struct {
    logic           rst;
    logic           st;
    logic           stl;
    logic           br;
    logic           ab;
    logic [D-1:0]   tg;
    logic           hl;
    logic [D-1:0]   pc;
    logic           bsy;
    logic           dn;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  typedef struct {
    logic [D-1:0]     pc;
    logic             bsy;
    logic             dn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stall;
  logic             branch;
  logic             abs_jump;
  logic [D-1:0]     target;
  logic             halt;
  logic [D-1:0]     prog_ctr;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] instr_cnt;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   total;
  int   bad;

  pc_fetch_ctrl #(.D(D), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .branch    (branch),
    .abs_jump  (abs_jump),
    .target    (target),
    .halt      (halt),
    .prog_ctr  (prog_ctr),
    .busy      (busy),
    .done      (done),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic rst, input logic st, input logic stl,
                        input logic br, input logic ab, input int tg,
                        input logic hl, input int pc, input logic bsy,
                        input logic dn, input int cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.br = br; v.ab = ab;
    v.tg  = tg[D-1:0]; v.hl = hl;
    v.pc  = pc[D-1:0]; v.bsy = bsy; v.dn = dn; v.cnt = cnt[CNT_W-1:0];
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs on the falling edge and queue what must follow.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset    = v.rst;
    start    = v.st;
    stall    = v.stl;
    branch   = v.br;
    abs_jump = v.ab;
    target   = v.tg;
    halt     = v.hl;
    e.pc = v.pc; e.bsy = v.bsy; e.dn = v.dn; e.cnt = v.cnt;
    scoreboard.push_back(e);
  endtask

  task automatic checkOne(input string name, input int idx,
                          input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
    end
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
    end else begin
      e = scoreboard.pop_front();
      checkOne("prog_ctr",  idx, int'(prog_ctr),  int'(e.pc));
      checkOne("busy",      idx, int'(busy),      int'(e.bsy));
      checkOne("done",      idx, int'(done),      int'(e.dn));
      checkOne("instr_cnt", idx, int'(instr_cnt), int'(e.cnt));
    end
  endtask

  initial begin
    vec_t v;
    int   idx;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0;
    abs_jump = 1'b0; target = '0; halt = 1'b0;

    //      rst st stl br ab tg    hl   pc   bsy dn cnt
    addVec(1, 0, 0, 0, 0, 0,    0,   0,   0, 0, 0);
    addVec(0, 0, 1, 1, 1, 77,   1,   0,   0, 0, 0);
    addVec(0, 1, 1, 0, 0, 0,    0,   0,   1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0,    0,   1,   1, 0, 1);
    addVec(0, 1, 0, 0, 0, 0,    0,   2,   1, 0, 2);
    addVec(0, 0, 0, 0, 0, 0,    0,   3,   1, 0, 3);
    addVec(0, 0, 0, 0, 0, 0,    0,   4,   1, 0, 4);
    addVec(0, 0, 0, 0, 0, 0,    0,   5,   1, 0, 5);
    addVec(0, 0, 0, 1, 0, 1023, 0,   4,   1, 0, 6);
    addVec(0, 0, 0, 1, 0, 1023, 0,   3,   1, 0, 7);
    addVec(0, 0, 0, 1, 0, 20,   0,   23,  1, 0, 8);
    addVec(0, 0, 0, 1, 1, 7,    0,   7,   1, 0, 9);
    addVec(0, 0, 0, 1, 1, 118,  0,   118, 1, 0, 10);
    addVec(0, 0, 0, 1, 1, 5,    1,   118, 0, 1, 11);
    addVec(0, 0, 1, 1, 1, 300,  1,   118, 0, 1, 11);
    addVec(0, 0, 0, 1, 0, 9,    0,   118, 0, 1, 11);
    addVec(0, 1, 0, 0, 0, 0,    0,   0,   1, 0, 0);
    addVec(0, 0, 0, 1, 1, 1023, 0,   1023,1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0,    0,   0,   1, 0, 2);
    addVec(0, 0, 0, 1, 0, 0,    0,   0,   1, 0, 3);
    addVec(0, 0, 0, 1, 0, 0,    0,   0,   1, 0, 4);
    addVec(0, 0, 0, 1, 0, 0,    0,   0,   1, 0, 5);
    addVec(0, 0, 0, 1, 1, 10,   0,   10,  1, 0, 6);
    addVec(0, 0, 1, 1, 1, 99,   1,   10,  1, 0, 6);
    addVec(0, 0, 1, 1, 0, 3,    1,   10,  1, 0, 6);
    addVec(0, 0, 0, 0, 0, 0,    1,   10,  0, 1, 7);
    addVec(0, 1, 0, 0, 0, 0,    0,   0,   1, 0, 0);
    addVec(0, 0, 0, 1, 1, 50,   0,   50,  1, 0, 1);
    addVec(1, 1, 0, 1, 1, 9,    1,   0,   0, 0, 0);
    addVec(0, 1, 0, 0, 0, 0,    0,   0,   1, 0, 0);
    addVec(0, 1, 0, 0, 0, 0,    0,   1,   1, 0, 1);
    addVec(0, 0, 0, 1, 0, 1022, 0,   1023,1, 0, 2);
    addVec(0, 0, 0, 0, 0, 0,    0,   0,   1, 0, 3);
    addVec(0, 0, 0, 0, 0, 0,    1,   0,   0, 1, 4);
    addVec(0, 1, 0, 0, 0, 0,    0,   0,   1, 0, 0);

    idx = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(idx);
      idx++;
    end

    // Run long enough that the 8-bit counter pins at 255 while the PC keeps moving.
    for (int n = 1; n <= 262; n++) begin
      v.rst = 0; v.st = 0; v.stl = 0; v.br = 0; v.ab = 0; v.tg = '0; v.hl = 0;
      v.pc  = n[D-1:0]; v.bsy = 1; v.dn = 0;
      v.cnt = (n > 255) ? 8'd255 : n[CNT_W-1:0];
      applyStimulus(v);
      checkOutput(idx);
      idx++;
    end
    v.hl = 1; v.pc = 10'd262; v.bsy = 0; v.dn = 1; v.cnt = 8'd255;
    applyStimulus(v);
    checkOutput(idx);
    idx++;

    v.rst = 1; v.hl = 0; v.pc = '0; v.bsy = 0; v.dn = 0; v.cnt = '0;
    applyStimulus(v);
    checkOutput(idx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
